// File: rtl/jtag_pkg.sv
// Shared definitions for the soft JTAG TAP: IEEE 1149.1 state encoding,
// instruction register length and the opcodes that select the data registers.
package jtag_pkg;

  localparam int IR_WIDTH = 8;

  localparam logic [IR_WIDTH-1:0] OP_ER1    = 8'h32;
  localparam logic [IR_WIDTH-1:0] OP_ER2    = 8'h38;
  localparam logic [IR_WIDTH-1:0] OP_IDCODE = 8'hE0;
  localparam logic [IR_WIDTH-1:0] OP_BYPASS = '1;

  typedef enum logic [3:0] {
    TLR      = 4'h0,
    RTI      = 4'h1,
    SEL_DR   = 4'h2,
    CAP_DR   = 4'h3,
    SH_DR    = 4'h4,
    EX1_DR   = 4'h5,
    PAUSE_DR = 4'h6,
    EX2_DR   = 4'h7,
    UPD_DR   = 4'h8,
    SEL_IR   = 4'h9,
    CAP_IR   = 4'hA,
    SH_IR    = 4'hB,
    EX1_IR   = 4'hC,
    PAUSE_IR = 4'hD,
    EX2_IR   = 4'hE,
    UPD_IR   = 4'hF
  } tap_state_e;

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP state register and IEEE 1149.1 next-state logic, clocked by JTCK and
// steered by JTMS; JRST forces Test-Logic-Reset on the next edge.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       JTCK,
  input  logic       JRST,
  input  logic       JTMS,
  output logic [3:0] state
);

  tap_state_e state_q;
  tap_state_e state_d;

  // NOTE: registered state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge JTCK) begin
    if (JRST) begin
      state_q <= TLR;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:      state_d = JTMS ? TLR    : RTI;
      RTI:      state_d = JTMS ? SEL_DR : RTI;
      SEL_DR:   state_d = JTMS ? SEL_IR : CAP_DR;
      CAP_DR:   state_d = JTMS ? EX1_DR : SH_DR;
      SH_DR:    state_d = JTMS ? EX1_DR : SH_DR;
      EX1_DR:   state_d = JTMS ? UPD_DR : PAUSE_DR;
      PAUSE_DR: state_d = JTMS ? EX2_DR : PAUSE_DR;
      EX2_DR:   state_d = JTMS ? UPD_DR : SH_DR;
      UPD_DR:   state_d = JTMS ? SEL_DR : RTI;
      SEL_IR:   state_d = JTMS ? TLR    : CAP_IR;
      CAP_IR:   state_d = JTMS ? EX1_IR : SH_IR;
      SH_IR:    state_d = JTMS ? EX1_IR : SH_IR;
      EX1_IR:   state_d = JTMS ? UPD_IR : PAUSE_IR;
      PAUSE_IR: state_d = JTMS ? EX2_IR : PAUSE_IR;
      EX2_IR:   state_d = JTMS ? UPD_IR : SH_IR;
      UPD_IR:   state_d = JTMS ? SEL_DR : RTI;
      default:  state_d = TLR;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// Soft TAP controller: instruction register, BYPASS and IDCODE registers,
// Moore control strobes for the ER1/ER2 user chains and the JTDO mux.
module jtag_tap_ctrl #(
  parameter int                          IR_WIDTH   = jtag_pkg::IR_WIDTH,
  parameter logic [31:0]                 IDCODE_VAL = 32'h0000_0001,
  parameter logic [jtag_pkg::IR_WIDTH-1:0] OP_ER1     = jtag_pkg::OP_ER1,
  parameter logic [jtag_pkg::IR_WIDTH-1:0] OP_ER2     = jtag_pkg::OP_ER2,
  parameter logic [jtag_pkg::IR_WIDTH-1:0] OP_IDCODE  = jtag_pkg::OP_IDCODE
) (
  input  logic JTCK,
  input  logic JRST,
  input  logic JTMS,
  input  logic JTDI,
  input  logic JTD1,
  input  logic JTD2,
  output logic JTDO,
  output logic JTDO_EN,
  output logic JSHIFT,
  output logic JUPDATE,
  output logic JCE1,
  output logic JCE2,
  output logic JRTI1,
  output logic JRTI2,
  output logic JRSTN
);

  import jtag_pkg::*;

  logic [3:0]          state_raw;
  tap_state_e          state;
  logic [IR_WIDTH-1:0] ir;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [31:0]         id_shift;
  logic                bypass_q;
  logic                sel1;
  logic                sel2;
  logic                selid;
  logic                selbyp;
  logic                active;
  logic                tlr_next;
  logic                in_cap_sh_dr;

  jtag_tap_fsm u_fsm (
    .JTCK  (JTCK),
    .JRST  (JRST),
    .JTMS  (JTMS),
    .state (state_raw)
  );

  assign state = tap_state_e'(state_raw);

  assign sel1   = (ir == IR_WIDTH'(OP_ER1));
  assign sel2   = (ir == IR_WIDTH'(OP_ER2));
  assign selid  = (ir == IR_WIDTH'(OP_IDCODE));
  assign selbyp = ~(sel1 | sel2 | selid);

  // Outputs are forced to their reset values for the whole cycle JRST is high.
  assign active = ~JRST;

  // Only TLR (hold) and Select-IR (escape) lead into TLR on a TMS=1 edge.
  assign tlr_next = JTMS & ((state == TLR) | (state == SEL_IR));

  always_ff @(posedge JTCK) begin
    if (JRST) begin
      ir       <= IR_WIDTH'(OP_IDCODE);
      ir_shift <= '0;
    end else begin
      case (state)
        CAP_IR:  ir_shift <= IR_WIDTH'(2'b01);
        SH_IR:   ir_shift <= {JTDI, ir_shift[IR_WIDTH-1:1]};
        default: ir_shift <= ir_shift;
      endcase
      if (tlr_next) begin
        ir <= IR_WIDTH'(OP_IDCODE);
      end else if (state == UPD_IR) begin
        ir <= ir_shift;
      end
    end
  end

  // Pause and all other non-capture/shift states leave the DRs untouched.
  always_ff @(posedge JTCK) begin
    if (JRST) begin
      id_shift <= '0;
      bypass_q <= 1'b0;
    end else begin
      case (state)
        CAP_DR: begin
          bypass_q <= 1'b0;
          if (selid) id_shift <= IDCODE_VAL;
        end
        SH_DR: begin
          if (selid)  id_shift <= {JTDI, id_shift[31:1]};
          if (selbyp) bypass_q <= JTDI;
        end
        default: begin
          id_shift <= id_shift;
          bypass_q <= bypass_q;
        end
      endcase
    end
  end

  assign in_cap_sh_dr = (state == CAP_DR) | (state == SH_DR);

  assign JSHIFT  = active & (state == SH_DR);
  assign JUPDATE = active & (state == UPD_DR);
  assign JCE1    = active & sel1 & in_cap_sh_dr;
  assign JCE2    = active & sel2 & in_cap_sh_dr;
  assign JRTI1   = active & sel1 & (state == RTI);
  assign JRTI2   = active & sel2 & (state == RTI);
  assign JRSTN   = active & (state != TLR);
  assign JTDO_EN = active & ((state == SH_IR) | (state == SH_DR));

  // Chain outputs pass straight through so the chains' own latency is preserved.
  always_comb begin
    JTDO = 1'b0;
    if (active) begin
      if (state == SH_IR) begin
        JTDO = ir_shift[0];
      end else if (state == SH_DR) begin
        if (sel1)       JTDO = JTD1;
        else if (sel2)  JTDO = JTD2;
        else if (selid) JTDO = id_shift[0];
        else            JTDO = bypass_q;
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: directed TAP sequences plus random
// TMS/TDI/JRST traffic, all outputs compared against a behavioural TAP model.
module tb_jtag_tap_ctrl;

  logic JTCK = 1'b0;
  logic JRST = 1'b1;
  logic JTMS = 1'b0;
  logic JTDI = 1'b0;
  logic JTD1 = 1'b0;
  logic JTD2 = 1'b0;
  logic JTDO, JTDO_EN, JSHIFT, JUPDATE, JCE1, JCE2, JRTI1, JRTI2, JRSTN;

  jtag_tap_ctrl dut (
    .JTCK    (JTCK),
    .JRST    (JRST),
    .JTMS    (JTMS),
    .JTDI    (JTDI),
    .JTD1    (JTD1),
    .JTD2    (JTD2),
    .JTDO    (JTDO),
    .JTDO_EN (JTDO_EN),
    .JSHIFT  (JSHIFT),
    .JUPDATE (JUPDATE),
    .JCE1    (JCE1),
    .JCE2    (JCE2),
    .JRTI1   (JRTI1),
    .JRTI2   (JRTI2),
    .JRSTN   (JRSTN)
  );

  always #5 JTCK = ~JTCK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a column (control pair, DR column, IR column) and a row within it.
  localparam int COL_CTRL = 0, COL_DR = 1, COL_IR = 2;
  localparam int PH_TLR = 0, PH_RTI = 1;
  localparam int PH_SEL = 0, PH_CAP = 1, PH_SH = 2, PH_EX1 = 3,
                 PH_PAUSE = 4, PH_EX2 = 5, PH_UPD = 6;

  int          m_col  = COL_CTRL;
  int          m_ph   = PH_TLR;
  int          m_ir   = 8'hE0;
  int          m_irsh = 0;
  logic [31:0] m_id   = '0;
  int          m_byp  = 0;

  logic obs_tdo, obs_shift, obs_upd, obs_ce1, obs_ce2, obs_rti1, obs_rti2, obs_rstn;
  int   cnt_shift_ce2 = 0, cnt_upd = 0, cnt_ce1 = 0;
  logic cap_ce2, cap_shift;

  task automatic model_edge(input logic tms, input logic tdi, input logic rst);
    bit s1, s2, sid;
    if (rst) begin
      m_col = COL_CTRL; m_ph = PH_TLR; m_ir = 8'hE0; m_irsh = 0; m_id = '0; m_byp = 0;
      return;
    end
    s1  = (m_ir == 8'h32);
    s2  = (m_ir == 8'h38);
    sid = (m_ir == 8'hE0);
    if (m_col == COL_IR) begin
      if (m_ph == PH_CAP)      m_irsh = 1;
      else if (m_ph == PH_SH)  m_irsh = (m_irsh >> 1) + (int'(tdi) * 128);
      else if (m_ph == PH_UPD) m_ir = m_irsh;
    end else if (m_col == COL_DR) begin
      if (m_ph == PH_CAP) begin
        m_byp = 0;
        if (sid) m_id = 32'h0000_0001;
      end else if (m_ph == PH_SH) begin
        if (sid) m_id = (m_id >> 1) | (32'(tdi) << 31);
        if (!s1 && !s2 && !sid) m_byp = int'(tdi);
      end
    end
    if (m_col == COL_CTRL) begin
      if (m_ph == PH_TLR) m_ph = tms ? PH_TLR : PH_RTI;
      else if (tms) begin m_col = COL_DR; m_ph = PH_SEL; end
    end else begin
      case (m_ph)
        PH_SEL: begin
          if (!tms) m_ph = PH_CAP;
          else if (m_col == COL_DR) m_col = COL_IR;
          else begin m_col = COL_CTRL; m_ph = PH_TLR; end
        end
        PH_CAP, PH_SH: m_ph = tms ? PH_EX1 : PH_SH;
        PH_EX1:        m_ph = tms ? PH_UPD : PH_PAUSE;
        PH_PAUSE:      m_ph = tms ? PH_EX2 : PH_PAUSE;
        PH_EX2:        m_ph = tms ? PH_UPD : PH_SH;
        default: begin
          if (tms) begin m_col = COL_DR; m_ph = PH_SEL; end
          else begin m_col = COL_CTRL; m_ph = PH_RTI; end
        end
      endcase
    end
    if (m_col == COL_CTRL && m_ph == PH_TLR) m_ir = 8'hE0;
  endtask

  // One JTCK cycle: drive on the falling edge, check mid-cycle, advance model on the rising edge.
  task automatic step(input logic tms, input logic tdi, input logic rst);
    bit s1, s2, sid, on, shdr, shir, capdr, updr, rti, tlr;
    logic e_tdo;
    @(negedge JTCK);
    JTMS = tms; JTDI = tdi; JRST = rst;
    JTD1 = 1'($urandom & 1);
    JTD2 = 1'($urandom & 1);
    #1;
    s1    = (m_ir == 8'h32);
    s2    = (m_ir == 8'h38);
    sid   = (m_ir == 8'hE0);
    on    = !rst;
    shdr  = on && m_col == COL_DR && m_ph == PH_SH;
    capdr = on && m_col == COL_DR && m_ph == PH_CAP;
    updr  = on && m_col == COL_DR && m_ph == PH_UPD;
    shir  = on && m_col == COL_IR && m_ph == PH_SH;
    rti   = on && m_col == COL_CTRL && m_ph == PH_RTI;
    tlr   = m_col == COL_CTRL && m_ph == PH_TLR;
    if (shir)      e_tdo = 1'(m_irsh & 1);
    else if (shdr) e_tdo = s1 ? JTD1 : s2 ? JTD2 : sid ? m_id[0] : 1'(m_byp);
    else           e_tdo = 1'b0;
    check("jtdo",    32'(JTDO),    32'(e_tdo));
    check("jtdo_en", 32'(JTDO_EN), 32'(shir | shdr));
    check("jshift",  32'(JSHIFT),  32'(shdr));
    check("jupdate", 32'(JUPDATE), 32'(updr));
    check("jce1",    32'(JCE1),    32'(s1 & (capdr | shdr)));
    check("jce2",    32'(JCE2),    32'(s2 & (capdr | shdr)));
    check("jrti1",   32'(JRTI1),   32'(s1 & rti));
    check("jrti2",   32'(JRTI2),   32'(s2 & rti));
    check("jrstn",   32'(JRSTN),   32'(on & !tlr));
    obs_tdo = JTDO; obs_shift = JSHIFT; obs_upd = JUPDATE; obs_ce1 = JCE1;
    obs_ce2 = JCE2; obs_rti1 = JRTI1; obs_rti2 = JRTI2; obs_rstn = JRSTN;
    if (JSHIFT && JCE2) cnt_shift_ce2++;
    if (JUPDATE) cnt_upd++;
    if (JCE1) cnt_ce1++;
    @(posedge JTCK);
    model_edge(tms, tdi, rst);
  endtask

  // From RTI: load an opcode LSB-first, return what shifted out, end in RTI.
  task automatic load_ir(input logic [7:0] op, output logic [7:0] cap);
    cap = '0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(i == 7, op[i], 1'b0);
      cap[i] = obs_tdo;
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  // From RTI: shift n bits through the selected DR, end in RTI.
  task automatic shift_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
    dout = '0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    cap_ce2   = obs_ce2;
    cap_shift = obs_shift;
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i], 1'b0);
      dout[i] = obs_tdo;
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic five_tms_to_rti(input string tag);
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom & 1), 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check(tag, 32'(obs_rstn), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  cap;
    logic [31:0] dout;
    logic [7:0]  op;

    // Reset, then TLR -> RTI.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("tlr_rstn", 32'(obs_rstn), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("rti_rstn", 32'(obs_rstn), 32'd1);

    // IDCODE selected straight out of reset.
    shift_dr(32, $urandom, dout);
    check("idcode_reset", dout, 32'h0000_0001);

    // Load ER2 and check the captured IR pattern and RTI strobes.
    load_ir(8'h38, cap);
    check("ir_capture_er2", 32'(cap), 32'h01);
    step(1'b0, 1'b0, 1'b0);
    check("jrti2_er2", 32'(obs_rti2), 32'd1);
    check("jrti1_er2", 32'(obs_rti1), 32'd0);

    // Four-bit ER2 DR shift.
    cnt_shift_ce2 = 0; cnt_upd = 0; cnt_ce1 = 0;
    shift_dr(4, 32'b1010, dout);
    check("capdr_jce2",   32'(cap_ce2),   32'd1);
    check("capdr_jshift", 32'(cap_shift), 32'd0);
    check("er2_shift_cycles", 32'(cnt_shift_ce2), 32'd4);
    check("er2_update_cycles", 32'(cnt_upd), 32'd1);
    check("er2_jce1_cycles", 32'(cnt_ce1), 32'd0);

    // BYPASS via all-ones: one-cycle echo of JTDI, leading zero.
    load_ir(8'hFF, cap);
    check("ir_capture_ff", 32'(cap), 32'h01);
    shift_dr(8, 32'hCA, dout);
    check("bypass_echo", dout, 32'h94);

    // Five TMS=1 from PauseDR with ER1 loaded.
    load_ir(8'h32, cap);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    five_tms_to_rti("pause_five_tms_tlr");
    step(1'b0, 1'b0, 1'b0);
    check("pause_recover_rti1", 32'(obs_rti1), 32'd0);
    shift_dr(32, $urandom, dout);
    check("pause_recover_idcode", dout, 32'h0000_0001);

    // JRST in the middle of an IR shift of ER1.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("jrst_shir_tlr", 32'(obs_rstn), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("jrst_shir_rti1", 32'(obs_rti1), 32'd0);
    check("jrst_shir_rti2", 32'(obs_rti2), 32'd0);
    shift_dr(32, $urandom, dout);
    check("jrst_shir_idcode", dout, 32'h0000_0001);

    // Random traffic: structured loads/shifts plus free-running TMS with rare JRST.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0:       op = 8'h32;
        1:       op = 8'h38;
        2:       op = 8'hE0;
        3:       op = 8'hFF;
        default: op = 8'($urandom);
      endcase
      load_ir(op, cap);
      check("ir_capture_rand", 32'(cap), 32'h01);
      for (int k = 0; k < int'($urandom_range(1, 3)); k++)
        shift_dr(int'($urandom_range(1, 32)), $urandom, dout);
      for (int k = 0; k < 60; k++)
        step(1'($urandom_range(0, 9) < 4), 1'($urandom & 1), 1'($urandom_range(0, 79) == 0));
      five_tms_to_rti("rand_five_tms_tlr");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
